// File: rtl/sound_ram_reader.sv
// Sound RAM byte reader: a one-word cache in front of an SDRAM read port.
// Fetches the 32-bit word holding ptr_i on a miss and serves bytes from it.
module sound_ram_reader #(
  parameter logic       ENABLE  = 1'b1,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [15:0] ptr_i,
  input  logic        inval_i,
  input  logic [15:0] inval_addr_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        timeout_o,
  output logic        mem_rd_o,
  output logic [20:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_q_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_r, state_nxt;
  logic [13:0] tag_r, req_tag_r;
  logic [31:0] word_r;
  logic        tag_valid_r, stale_r;
  logic [7:0]  timer_r;
  logic [20:0] addr_r;

  logic        hit, inval_tag, inval_req, inval_ptr, fill, abort;
  logic [20:0] req_addr;
  logic        unused_bits;

  // Sound RAM lives at byte 0x4_0000, i.e. word address 0x1_0000.
  assign req_addr    = {4'b0, 1'b1, 2'b0, ptr_i[15:2]};
  assign hit         = tag_valid_r && (tag_r == ptr_i[15:2]);
  assign inval_tag   = inval_i && (inval_addr_i[15:2] == tag_r);
  assign inval_req   = inval_i && (inval_addr_i[15:2] == req_tag_r);
  assign inval_ptr   = inval_i && (inval_addr_i[15:2] == ptr_i[15:2]);
  assign fill        = (state_r == WAIT) && mem_ready_i;
  assign abort       = (state_r == WAIT) && !mem_ready_i && (timer_r <= 8'd1);
  assign unused_bits = ^inval_addr_i[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_logic) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // this block leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (ENABLE && enable_i && !hit) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (fill || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_o   = ENABLE && (state_r == REQ);
    mem_addr_o = (state_r == REQ) ? req_addr : addr_r;
    data_o     = word_r[{ptr_i[1:0], 3'b000} +: 8];
    valid_o    = ENABLE && enable_i && hit && !inval_tag;
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      tag_r       <= '0;
      req_tag_r   <= '0;
      word_r      <= '0;
      tag_valid_r <= 1'b0;
      stale_r     <= 1'b0;
      timer_r     <= '0;
      addr_r      <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if (abort) timeout_o <= 1'b1;

      case (state_r)
        REQ: begin
          req_tag_r <= ptr_i[15:2];
          addr_r    <= req_addr;
          // A write landing in the issue cycle already makes the fetch stale.
          stale_r   <= inval_ptr;
          timer_r   <= TIMEOUT;
        end
        WAIT: begin
          if (!mem_ready_i && timer_r != 8'd0) timer_r <= timer_r - 8'd1;
          if (inval_req) stale_r <= 1'b1;
        end
        default: ;
      endcase

      // A write to the in-flight word, even in the ready cycle, drops the fill.
      if (fill) begin
        word_r      <= mem_q_i;
        tag_r       <= req_tag_r;
        tag_valid_r <= !stale_r && !inval_req;
      end else if (inval_tag) begin
        tag_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sound_ram_reader.sv
// Bench for sound_ram_reader: byte-array sound RAM model, latency-programmable
// memory responder, and a scoreboard comparing each served byte against RAM.
`timescale 1ns/1ps
module tb_sound_ram_reader;

  logic        clk_logic = 1'b0;
  logic        reset = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] ptr_i = '0;
  logic        inval_i = 1'b0;
  logic [15:0] inval_addr_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_q_i = '0;

  logic [7:0]  data_o;
  logic        valid_o, timeout_o, mem_rd_o;
  logic [20:0] mem_addr_o;

  logic [7:0]  off_data;
  logic        off_valid, off_timeout, off_rd;
  logic [20:0] off_addr;

  always #5 clk_logic = ~clk_logic;

  sound_ram_reader #(.ENABLE(1'b1), .TIMEOUT(8'd4)) dut (
    .clk_logic(clk_logic), .reset(reset), .enable_i(enable_i), .ptr_i(ptr_i),
    .inval_i(inval_i), .inval_addr_i(inval_addr_i), .data_o(data_o),
    .valid_o(valid_o), .timeout_o(timeout_o), .mem_rd_o(mem_rd_o),
    .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i)
  );

  sound_ram_reader #(.ENABLE(1'b0), .TIMEOUT(8'd4)) dut_off (
    .clk_logic(clk_logic), .reset(reset), .enable_i(enable_i), .ptr_i(ptr_i),
    .inval_i(inval_i), .inval_addr_i(inval_addr_i), .data_o(off_data),
    .valid_o(off_valid), .timeout_o(off_timeout), .mem_rd_o(off_rd),
    .mem_addr_o(off_addr), .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i)
  );

  typedef struct {
    logic [15:0] ptr;
    logic [7:0]  b;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  ram [65536];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  bit          silent = 1'b0;
  bit          stray_req = 1'b0;
  bit          off_bad = 1'b0;
  int          rd_count = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_word = '0;
  logic [20:0] pend_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [13:0] w);
    return {ram[{w, 2'b11}], ram[{w, 2'b10}], ram[{w, 2'b01}], ram[{w, 2'b00}]};
  endfunction

  task automatic step();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic set_ptr(input logic [15:0] p);
    step();
    ptr_i = p;
    exp_q.push_back('{ptr: p, b: ram[p]});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk_logic);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Memory responder: snapshots the word when the read is issued and returns
  // it lat cycles into WAIT; silent mode never answers.
  always @(negedge clk_logic) begin
    mem_ready_i = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_ready_i = 1'b1;
        mem_q_i     = pend_word;
        check("addr_hold", mem_addr_o, pend_addr);
      end
    end
    if (stray_req) begin
      mem_ready_i = 1'b1;
      mem_q_i     = 32'hDEAD_BEEF;
      stray_req   = 1'b0;
    end
    if (mem_rd_o) begin
      rd_count++;
      check("rd_addr", mem_addr_o, (32'h0004_0000 + 32'(ptr_i)) >> 2);
      if (!silent) begin
        pend_cnt  = lat;
        pend_addr = mem_addr_o;
        pend_word = word_of(mem_addr_o[13:0]);
      end
    end
  end

  // Scoreboard monitor: the first valid byte after a pointer change is compared.
  always @(negedge clk_logic) begin
    off_bad = off_bad | off_rd | off_valid | off_timeout;
    if (exp_q.size() != 0 && valid_o) begin
      mon_e = exp_q.pop_front();
      check("sb_data", data_o, mon_e.b);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, cyc, k;
    logic [15:0] a, p, tptr;

    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h1234] = 8'hAA; ram[16'h1235] = 8'hBB;
    ram[16'h1236] = 8'hCC; ram[16'h1237] = 8'hDD;

    repeat (3) step();
    @(negedge clk_logic);
    check("reset_valid", valid_o, 0);
    check("reset_rd", mem_rd_o, 0);
    check("reset_timeout", timeout_o, 0);
    check("reset_data", data_o, 0);
    step();
    reset = 1'b0;

    // Miss with 4-cycle memory: valid six cycles after the pointer change.
    lat = 4;
    rd0 = rd_count;
    step();
    enable_i = 1'b1;
    ptr_i = 16'h1234;
    exp_q.push_back('{ptr: 16'h1234, b: ram[16'h1234]});
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(negedge clk_logic);
      #1;
      if (exp_q.size() != 0) cyc++;
    end
    check("miss_latency_lat4", cyc, 6);
    check("fetch_count_1234", rd_count - rd0, 1);
    exp_q.delete();

    rd0 = rd_count;
    for (int i = 1; i < 4; i++) begin
      set_ptr(16'h1234 + 16'(i));
      drain("hit_same_word");
    end
    check("no_fetch_on_hits", rd_count - rd0, 0);
    set_ptr(16'h1238);
    drain("next_word");
    check("fetch_count_1238", rd_count - rd0, 1);

    // One-cycle memory: minimum miss latency.
    lat = 1;
    step();
    ptr_i = 16'h2230;
    exp_q.push_back('{ptr: 16'h2230, b: ram[16'h2230]});
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(negedge clk_logic);
      #1;
      if (exp_q.size() != 0) cyc++;
    end
    check("miss_latency_lat1", cyc, 3);
    exp_q.delete();

    // Invalidation of the cached word versus an unrelated address.
    lat = 2;
    set_ptr(16'h1234);
    drain("refill_1234");
    rd0 = rd_count;
    step();
    inval_addr_i = 16'h2000;
    inval_i = 1'b1;
    @(negedge clk_logic);
    check("inval_other_same_cycle", valid_o, 1);
    step();
    inval_i = 1'b0;
    @(negedge clk_logic);
    check("inval_other_next_cycle", valid_o, 1);
    check("inval_other_no_fetch", rd_count - rd0, 0);
    step();
    ram[16'h1236] = 8'h5A;
    inval_addr_i = 16'h1236;
    inval_i = 1'b1;
    @(negedge clk_logic);
    check("inval_hit_same_cycle", valid_o, 0);
    step();
    inval_i = 1'b0;
    @(negedge clk_logic);
    check("inval_hit_next_cycle", valid_o, 0);
    exp_q.push_back('{ptr: 16'h1234, b: ram[16'h1234]});
    drain("refetch_after_inval");
    check("refetch_count", rd_count - rd0, 1);
    set_ptr(16'h1236);
    drain("new_byte_after_inval");
    check("no_fetch_after_refill", rd_count - rd0, 1);

    // Write to the in-flight word during WAIT: returned data dropped.
    lat = 4;
    rd0 = rd_count;
    step();
    ptr_i = 16'h3000;
    repeat (3) step();
    ram[16'h3000] = ~ram[16'h3000];
    inval_addr_i = 16'h3000;
    inval_i = 1'b1;
    step();
    inval_i = 1'b0;
    exp_q.push_back('{ptr: 16'h3000, b: ram[16'h3000]});
    drain("stale_during_wait");
    check("stale_refetch_count", rd_count - rd0, 2);

    // Write coincident with mem_ready_i for the same word.
    rd0 = rd_count;
    step();
    ptr_i = 16'h3004;
    repeat (5) step();
    ram[16'h3004] = ~ram[16'h3004];
    inval_addr_i = 16'h3004;
    inval_i = 1'b1;
    step();
    inval_i = 1'b0;
    exp_q.push_back('{ptr: 16'h3004, b: ram[16'h3004]});
    drain("inval_with_ready");
    check("coincident_refetch_count", rd_count - rd0, 2);

    // Pointer moves to another word mid-fetch.
    rd0 = rd_count;
    step();
    ptr_i = 16'h7000;
    step();
    step();
    ptr_i = 16'h7100;
    exp_q.push_back('{ptr: 16'h7100, b: ram[16'h7100]});
    drain("ptr_change_in_wait");
    check("ptr_change_fetch_count", rd_count - rd0, 2);

    // enable_i drops mid-fetch: fill completes, nothing new issued.
    lat = 3;
    rd0 = rd_count;
    step();
    ptr_i = 16'h6000;
    step();
    step();
    enable_i = 1'b0;
    repeat (8) step();
    check("disabled_valid", valid_o, 0);
    check("disabled_fetch_count", rd_count - rd0, 1);
    step();
    enable_i = 1'b1;
    exp_q.push_back('{ptr: 16'h6000, b: ram[16'h6000]});
    drain("reenable_hit");
    check("reenable_no_fetch", rd_count - rd0, 1);

    // Pointer wrap is an ordinary miss.
    rd0 = rd_count;
    set_ptr(16'hFFFF);
    drain("wrap_ffff");
    set_ptr(16'h0000);
    drain("wrap_0000");
    check("wrap_fetch_count", rd_count - rd0, 2);

    // Randomised pointer walk with occasional sound RAM writes.
    for (int it = 0; it < 200; it++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? {ptr_i[15:2], 2'($urandom)} : 16'($urandom);
        step();
        ram[a] = 8'($urandom);
        inval_addr_i = a;
        inval_i = 1'b1;
        step();
        inval_i = 1'b0;
      end
      k = $urandom_range(0, 9);
      if (k < 4)      p = {ptr_i[15:2], 2'($urandom)};
      else if (k < 6) p = ptr_i + 16'd1;
      else            p = 16'($urandom);
      set_ptr(p);
      drain("random_walk");
    end
    check("no_timeout_yet", timeout_o, 0);

    // Silent memory: abort after four WAIT cycles, then retry.
    silent = 1'b1;
    tptr = {~ptr_i[15:2], 2'b00};
    step();
    ptr_i = tptr;
    k = 0;
    while (!mem_rd_o && k < 10) begin
      @(negedge clk_logic);
      #1;
      k++;
    end
    check("timeout_req_seen", mem_rd_o, 1);
    repeat (4) @(negedge clk_logic);
    check("timeout_not_yet", timeout_o, 0);
    @(negedge clk_logic);
    check("timeout_set", timeout_o, 1);
    @(negedge clk_logic);
    check("retry_req", mem_rd_o, 1);

    // Reset mid-WAIT, then a stray ready must not fill the cache.
    step();
    step();
    reset = 1'b1;
    enable_i = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk_logic);
    check("reset_clears_timeout", timeout_o, 0);
    step();
    stray_req = 1'b1;
    repeat (3) step();
    rd0 = rd_count;
    enable_i = 1'b1;
    repeat (4) step();
    check("stray_ready_no_fill", rd_count - rd0, 1);
    check("stray_ready_no_valid", valid_o, 0);

    check("enable_param_off", off_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
